fifo_wr_arbiter: RTL and testbench

//   Round-robin write-port arbiter in front of the async fifo write domain.

---
 rtl/fifo_wr_arbiter.sv | 107 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ producers, bursts of up to BURST beats.
// Optional FIFO_ARB_STATS_EN adds a saturating stall_cnt output.
module fifo_wr_arbiter #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  full,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                    state;
  logic [IDW-1:0]            owner, rr_ptr, nxt_owner, owner_inc, idx;
  logic [IDW:0]              sum;
  logic [CW-1:0]             beat_cnt;
  logic                      found, own_vld, accept, last_beat;
  logic [NREQ-1:0][DSIZE-1:0] data_arr;

  assign data_arr  = req_data;
  assign own_vld   = req_valid[owner];
  assign accept    = own_vld & ~full;
  assign last_beat = (beat_cnt == CW'(BURST-1));
  assign owner_inc = (owner == IDW'(NREQ-1)) ? '0 : owner + 1'b1;
  assign grant_id  = owner;
  assign busy      = (state == GRANT);

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    nxt_owner = rr_ptr;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        nxt_owner = idx;
      end
    end
  end

  // Zero-latency pass-through: the FIFO samples winc/wdata on the same edge.
  always_comb begin
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    if (state == GRANT && !wrst) begin
      req_ready[owner] = ~full;
      winc             = accept;
      wdata            = data_arr[owner];
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          owner    <= nxt_owner;
          beat_cnt <= '0;
          state    <= GRANT;
        end
        GRANT: begin
          if (!own_vld || (accept && last_beat)) begin
            state  <= IDLE;
            rr_ptr <= owner_inc;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge wclk) begin
    if (wrst)
      stall_cnt <= '0;
    else if (state == GRANT && own_vld && full && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, BURST=4, DSIZE=8) with per-requester source queues and a write sink.
module tb_fifo_wr_arbiter;
  logic        wclk, wrst, full, winc, busy;
  logic [3:0]  req_valid, req_ready, vld_or;
  logic [31:0] req_data;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  logic [7:0] src [4][32];
  int         head [4];
  int         tail [4];
  logic [7:0] sink [64];
  int         ns;
  int         ntests, nfail;

  fifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .BURST(4)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .winc(winc), .wdata(wdata), .full(full),
    .grant_id(grant_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = (head[i] < tail[i]) | vld_or[i];
      req_data[i*8 +: 8]  = (head[i] < tail[i]) ? src[i][head[i]] : 8'h00;
    end
    #1;
  endtask

  task automatic load(input int i, input logic [7:0] base, input int n);
    head[i] = 0;
    tail[i] = n;
    for (int k = 0; k < n; k++) src[i][k] = base + 8'(k);
  endtask

  // Sample the handshake mid-cycle, take the edge, then retire accepted beats.
  task automatic tick();
    logic [3:0] acc;
    logic       w;
    logic [7:0] d;
    acc = req_valid & req_ready;
    w   = winc;
    d   = wdata;
    if (full) chk("no_write_when_full", {31'd0, w}, 32'd0);
    @(posedge wclk);
    #1;
    if (w) begin
      sink[ns] = d;
      ns++;
    end
    for (int i = 0; i < 4; i++) if (acc[i]) head[i]++;
    drive();
  endtask

  initial begin
    ntests = 0; nfail = 0; ns = 0;
    for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
    wrst = 1'b1; full = 1'b0; vld_or = 4'hF;
    drive();

    // 1: reset held with all requesters valid
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_winc", {31'd0, winc}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    end
    wrst = 1'b0; vld_or = 4'h0;
    drive();
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_wdata", {24'd0, wdata}, 32'd0);

    // 2: lone requester 2, six beats -> burst of 4, bubble, burst of 2
    ns = 0;
    load(2, 8'h10, 6);
    drive();
    chk("t2_latency_ready", {28'd0, req_ready}, 32'd0);
    tick();
    chk("t2_grant_id", {30'd0, grant_id}, 32'd2);
    for (int k = 0; k < 4; k++) begin
      chk("t2_ready", {28'd0, req_ready}, 32'h4);
      chk("t2_winc", {31'd0, winc}, 32'd1);
      chk("t2_wdata", {24'd0, wdata}, 32'h10 + k);
      tick();
    end
    chk("t2_bubble_busy", {31'd0, busy}, 32'd0);
    chk("t2_bubble_winc", {31'd0, winc}, 32'd0);
    tick();
    chk("t2_regrant_id", {30'd0, grant_id}, 32'd2);
    for (int k = 4; k < 6; k++) begin
      chk("t2_winc2", {31'd0, winc}, 32'd1);
      chk("t2_wdata2", {24'd0, wdata}, 32'h10 + k);
      tick();
    end
    chk("t2_drop_busy", {31'd0, busy}, 32'd1);
    chk("t2_drop_winc", {31'd0, winc}, 32'd0);
    tick();
    chk("t2_end_busy", {31'd0, busy}, 32'd0);
    chk("t2_count", ns, 32'd6);
    for (int k = 0; k < 6; k++) chk("t2_order", {24'd0, sink[k]}, 32'h10 + k);

    // 3: all four continuously valid, fresh rr_ptr
    wrst = 1'b1;
    drive();
    tick();
    wrst = 1'b0;
    for (int i = 0; i < 4; i++) load(i, 8'(i * 64), 8);
    drive();
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("t3_grant_order", {30'd0, grant_id}, g % 4);
      for (int b = 0; b < 4; b++) begin
        chk("t3_winc", {31'd0, winc}, 32'd1);
        chk("t3_wdata", {24'd0, wdata}, ((g % 4) * 64) + (g / 4) * 4 + b);
        tick();
      end
      chk("t3_gap_busy", {31'd0, busy}, 32'd0);
    end
    for (int i = 0; i < 4; i++) head[i] = tail[i];
    drive();
    tick();

    // 4: requester 1 stalled by full for 5 cycles after two beats
    ns = 0;
    load(1, 8'hA0, 4);
    drive();
    tick();
    chk("t4_grant_id", {30'd0, grant_id}, 32'd1);
    for (int b = 0; b < 2; b++) begin
      chk("t4_wdata_pre", {24'd0, wdata}, 32'hA0 + b);
      tick();
    end
    full = 1'b1;
    drive();
    for (int c = 0; c < 5; c++) begin
      chk("t4_stall_winc", {31'd0, winc}, 32'd0);
      chk("t4_stall_ready", {28'd0, req_ready}, 32'd0);
      chk("t4_stall_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    full = 1'b0;
    drive();
    for (int b = 2; b < 4; b++) begin
      chk("t4_winc_post", {31'd0, winc}, 32'd1);
      chk("t4_wdata_post", {24'd0, wdata}, 32'hA0 + b);
      tick();
    end
    chk("t4_end_busy", {31'd0, busy}, 32'd0);
    chk("t4_count", ns, 32'd4);
    for (int k = 0; k < 4; k++) chk("t4_order", {24'd0, sink[k]}, 32'hA0 + k);
`ifdef FIFO_ARB_STATS_EN
    chk("t4_stall_cnt", {16'd0, stall_cnt}, 32'd5);
`endif

    // 5: requester 0 drops after one beat while requester 3 waits
    load(0, 8'h55, 1);
    drive();
    tick();
    load(3, 8'h77, 2);
    drive();
    chk("t5_grant0", {30'd0, grant_id}, 32'd0);
    chk("t5_wdata0", {24'd0, wdata}, 32'h55);
    tick();
    chk("t5_drop_busy", {31'd0, busy}, 32'd1);
    chk("t5_drop_winc", {31'd0, winc}, 32'd0);
    tick();
    chk("t5_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("t5_grant3", {30'd0, grant_id}, 32'd3);
    chk("t5_wdata3", {24'd0, wdata}, 32'h77);
    tick();
    chk("t5_wdata3b", {24'd0, wdata}, 32'h78);
    tick();
    tick();
    chk("t5_end_busy", {31'd0, busy}, 32'd0);

    // 6: reset pulse in the middle of requester 2's burst
    ns = 0;
    load(2, 8'hC0, 4);
    drive();
    tick();
    chk("t6_grant2", {30'd0, grant_id}, 32'd2);
    chk("t6_wdata", {24'd0, wdata}, 32'hC0);
    tick();
    wrst = 1'b1;
    load(1, 8'hB0, 1);
    drive();
    chk("t6_rst_winc", {31'd0, winc}, 32'd0);
    chk("t6_rst_ready", {28'd0, req_ready}, 32'd0);
    tick();
    wrst = 1'b0;
    drive();
    chk("t6_post_busy", {31'd0, busy}, 32'd0);
    chk("t6_post_id", {30'd0, grant_id}, 32'd0);
    chk("t6_count", ns, 32'd1);
    tick();
    chk("t6_lowest_grant", {30'd0, grant_id}, 32'd1);
    chk("t6_wdata_b0", {24'd0, wdata}, 32'hB0);
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
